// File: rtl/alu_seq_ctrl_if.sv
// Opcode definitions and the request/ALU bundle for alu_seq_ctrl.
//
// alu_seq_ctrl_pkg : op_mne opcode encoding shared by requesters and the ALU.
// alu_seq_ctrl_if  : groups the two requester ports, the result/status outputs
//                    and the shared 8-bit ALU connection.
//   master : requester/ALU side (drives REQn/OPn/An/Bn/SCINn, ALU_OUT, ALU_SC_OUT)
//   slave  : controller side (drives ACKn, RESULT, SC_RESULT, ZERO_RESULT, BUSY,
//            ALU_A, ALU_B, ALU_OP, ALU_SC_IN)

package alu_seq_ctrl_pkg;
    typedef enum logic [2:0] {
        kAND  = 3'd0,
        kOR   = 3'd1,
        kXOR  = 3'd2,
        kADD  = 3'd3,
        kSUB  = 3'd4,
        kLSH  = 3'd5,
        kRSH  = 3'd6,
        kPASS = 3'd7
    } op_mne;
endpackage

interface alu_seq_ctrl_if;
    logic        REQ0, REQ1;
    logic [2:0]  OP0, OP1;
    logic [15:0] A0, B0, A1, B1;
    logic        SCIN0, SCIN1;
    logic        ACK0, ACK1;
    logic [15:0] RESULT;
    logic        SC_RESULT;
    logic        ZERO_RESULT;
    logic        BUSY;
    logic [7:0]  ALU_A, ALU_B;
    logic [2:0]  ALU_OP;
    logic        ALU_SC_IN;
    logic [7:0]  ALU_OUT;
    logic        ALU_SC_OUT;

    modport master (
        output REQ0, REQ1, OP0, OP1, A0, B0, A1, B1, SCIN0, SCIN1,
        output ALU_OUT, ALU_SC_OUT,
        input  ACK0, ACK1, RESULT, SC_RESULT, ZERO_RESULT, BUSY,
        input  ALU_A, ALU_B, ALU_OP, ALU_SC_IN
    );

    modport slave (
        input  REQ0, REQ1, OP0, OP1, A0, B0, A1, B1, SCIN0, SCIN1,
        input  ALU_OUT, ALU_SC_OUT,
        output ACK0, ACK1, RESULT, SC_RESULT, ZERO_RESULT, BUSY,
        output ALU_A, ALU_B, ALU_OP, ALU_SC_IN
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: arbitrates two requesters and runs one 16-bit operation as two
// byte passes through a shared external 8-bit combinational ALU.
//
// Ports:
//   CLK      : rising-edge clock
//   RESET_N  : asynchronous active-low reset
//   bus      : alu_seq_ctrl_if.slave -- requester inputs, ACK0/ACK1 pulses,
//              RESULT/SC_RESULT/ZERO_RESULT, BUSY, and the ALU drive/return.

module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET_N,
    alu_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        scin_q, scin_d;
    logic        carry_q, carry_d;
    logic [7:0]  part_q, part_d;
    logic [15:0] result_q, result_d;
    logic        sc_q, sc_d;
    logic        zero_q, zero_d;

    logic        winner;
    logic        shift_op;
    logic        hi_first;
    logic        use_hi;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_sc_in;

    // Tie goes to the requester that was not granted last.
    assign winner   = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;
    assign shift_op = (op_q == kLSH) || (op_q == kRSH);
    assign hi_first = (op_q == kRSH);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        scin_d    = scin_q;
        carry_d   = carry_q;
        part_d    = part_q;
        result_d  = result_q;
        sc_d      = sc_q;
        zero_d    = zero_q;
        use_hi    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = kAND;
        alu_sc_in = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.REQ0 | bus.REQ1) begin
                    state_d = PASS1;
                    gnt_d   = winner;
                    last_d  = winner;
                    op_d    = winner ? bus.OP1   : bus.OP0;
                    a_d     = winner ? bus.A1    : bus.A0;
                    b_d     = winner ? bus.B1    : bus.B0;
                    scin_d  = winner ? bus.SCIN1 : bus.SCIN0;
                end
            end
            PASS1: begin
                state_d   = PASS2;
                use_hi    = hi_first;
                alu_a     = use_hi ? a_q[15:8] : a_q[7:0];
                alu_b     = use_hi ? b_q[15:8] : b_q[7:0];
                alu_op    = op_q;
                alu_sc_in = shift_op ? scin_q : 1'b0;
                // First byte is staged so RESULT only changes at the PASS2 edge.
                part_d    = bus.ALU_OUT;
                carry_d   = bus.ALU_SC_OUT;
            end
            PASS2: begin
                state_d   = DONE;
                use_hi    = ~hi_first;
                alu_a     = use_hi ? a_q[15:8] : a_q[7:0];
                alu_b     = use_hi ? b_q[15:8] : b_q[7:0];
                alu_op    = op_q;
                alu_sc_in = shift_op ? carry_q : 1'b0;
                result_d  = hi_first ? {part_q, bus.ALU_OUT} : {bus.ALU_OUT, part_q};
                sc_d      = shift_op ? bus.ALU_SC_OUT : 1'b0;
                zero_d    = (result_d == '0);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            scin_q   <= 1'b0;
            carry_q  <= 1'b0;
            part_q   <= '0;
            result_q <= '0;
            sc_q     <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            scin_q   <= scin_d;
            carry_q  <= carry_d;
            part_q   <= part_d;
            result_q <= result_d;
            sc_q     <= sc_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ACK0        = (state_q == DONE) && !gnt_q;
    assign bus.ACK1        = (state_q == DONE) &&  gnt_q;
    assign bus.BUSY        = (state_q != IDLE);
    assign bus.RESULT      = result_q;
    assign bus.SC_RESULT   = sc_q;
    assign bus.ZERO_RESULT = zero_q;
    assign bus.ALU_A       = alu_a;
    assign bus.ALU_B       = alu_b;
    assign bus.ALU_OP      = alu_op;
    assign bus.ALU_SC_IN   = alu_sc_in;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: models the external 8-bit ALU, drives
// directed and random operations, and compares against a 16-bit reference.

module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // External shared 8-bit ALU (combinational).
    always_comb begin
        bus.ALU_OUT    = '0;
        bus.ALU_SC_OUT = 1'b0;
        case (bus.ALU_OP)
            kAND: bus.ALU_OUT = bus.ALU_A & bus.ALU_B;
            kOR:  bus.ALU_OUT = bus.ALU_A | bus.ALU_B;
            kXOR: bus.ALU_OUT = bus.ALU_A ^ bus.ALU_B;
            kADD: {bus.ALU_SC_OUT, bus.ALU_OUT} = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B} + {8'd0, bus.ALU_SC_IN};
            kSUB: {bus.ALU_SC_OUT, bus.ALU_OUT} = {1'b0, bus.ALU_A} - {1'b0, bus.ALU_B};
            kLSH: {bus.ALU_SC_OUT, bus.ALU_OUT} = {bus.ALU_A, bus.ALU_SC_IN};
            kRSH: {bus.ALU_OUT, bus.ALU_SC_OUT} = {bus.ALU_SC_IN, bus.ALU_A};
            default: bus.ALU_OUT = bus.ALU_A;
        endcase
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: shifts are 17-bit shifts through SCIN; bitwise ops
    // are 16-bit; ADD/SUB run as two independent bytes since no carry chains.
    function automatic void ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic scin, output logic [15:0] res, output logic sc,
                                   output logic mid_carry);
        sc = 1'b0;
        mid_carry = 1'b0;
        case (op)
            kLSH: begin res = {a[14:0], scin}; sc = a[15]; mid_carry = a[7]; end
            kRSH: begin res = {scin, a[15:1]}; sc = a[0];  mid_carry = a[8]; end
            kAND: res = a & b;
            kOR:  res = a | b;
            kXOR: res = a ^ b;
            kADD: res = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
            kSUB: res = {a[15:8] - b[15:8], a[7:0] - b[7:0]};
            default: res = a;
        endcase
    endfunction

    task automatic drive(input int r, input logic req, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic scin);
        if (r == 0) begin
            bus.REQ0 = req; bus.OP0 = op; bus.A0 = a; bus.B0 = b; bus.SCIN0 = scin;
        end else begin
            bus.REQ1 = req; bus.OP1 = op; bus.A1 = a; bus.B1 = b; bus.SCIN1 = scin;
        end
    endtask

    // Call at a negedge with the controller idle.
    task automatic run_op(input int r, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic scin);
        logic [15:0] er;
        logic        es, ec, shift, hi_first, got;
        int          cyc;
        ref_op(op, a, b, scin, er, es, ec);
        shift    = (op == kLSH) || (op == kRSH);
        hi_first = (op == kRSH);
        drive(r, 1'b1, op, a, b, scin);
        @(posedge clk);
        @(negedge clk);
        check("pass1_busy", bus.BUSY, 1);
        check("pass1_alu_a", bus.ALU_A, hi_first ? a[15:8] : a[7:0]);
        check("pass1_alu_b", bus.ALU_B, hi_first ? b[15:8] : b[7:0]);
        check("pass1_alu_op", bus.ALU_OP, op);
        check("pass1_sc_in", bus.ALU_SC_IN, shift ? scin : 1'b0);
        // Operands change after grant; they must be ignored.
        drive(r, 1'b1, op ^ 3'd1, 16'h0000, ~b, ~scin);
        @(negedge clk);
        check("pass2_alu_a", bus.ALU_A, hi_first ? a[7:0] : a[15:8]);
        check("pass2_sc_in", bus.ALU_SC_IN, shift ? ec : 1'b0);
        cyc = 2;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.ACK0 | bus.ACK1) got = 1'b1;
        end
        check("ack_seen", got, 1);
        check("ack_latency", cyc, 3);
        check("ack_which", {bus.ACK1, bus.ACK0}, (r == 0) ? 2'b01 : 2'b10);
        drive(r, 1'b0, op, a, b, scin);
        check("result", bus.RESULT, er);
        check("sc_result", bus.SC_RESULT, es);
        check("zero_result", bus.ZERO_RESULT, (er == 16'h0000));
        @(negedge clk);
        check("idle_busy", bus.BUSY, 0);
        check("idle_acks", {bus.ACK1, bus.ACK0}, 2'b00);
        check("idle_alu_op", bus.ALU_OP, kAND);
        check("result_hold", bus.RESULT, er);
    endtask

    initial begin
        int          ack_who [4];
        int          ack_cyc [4];
        int          n_ack;
        logic        overlap;
        logic        late_ack;

        rst_n = 1'b0;
        drive(0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", bus.BUSY, 0);
        check("rst_acks", {bus.ACK1, bus.ACK0}, 2'b00);
        check("rst_result", bus.RESULT, 16'h0000);
        check("rst_sc", bus.SC_RESULT, 0);
        check("rst_zero", bus.ZERO_RESULT, 1);
        check("rst_alu_ab", {bus.ALU_A, bus.ALU_B}, 16'h0000);
        check("rst_alu_op", bus.ALU_OP, kAND);
        check("rst_alu_sc", bus.ALU_SC_IN, 0);

        // Both requesters held from reset: strict alternation starting at 0.
        drive(0, 1'b1, kXOR, 16'h1234, 16'h00FF, 1'b0);
        drive(1, 1'b1, kAND, 16'hFFFF, 16'h0F0F, 1'b0);
        for (int i = 0; i < 4; i++) begin ack_who[i] = -1; ack_cyc[i] = -1; end
        n_ack = 0;
        overlap = 1'b0;
        rst_n = 1'b1;
        for (int c = 1; c <= 24 && n_ack < 4; c++) begin
            @(negedge clk);
            if (bus.ACK0 && bus.ACK1) overlap = 1'b1;
            if (bus.ACK0 || bus.ACK1) begin
                ack_who[n_ack] = bus.ACK1 ? 1 : 0;
                ack_cyc[n_ack] = c;
                n_ack++;
            end
        end
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        check("tie_ack_count", n_ack, 4);
        check("tie_overlap", overlap, 0);
        for (int i = 0; i < 4; i++) begin
            check("tie_order", ack_who[i], i % 2);
            check("tie_cycle", ack_cyc[i], 3 + 4 * i);
        end
        @(negedge clk);

        // Directed operations.
        run_op(0, kLSH, 16'h80FF, 16'h0000, 1'b1);
        run_op(1, kRSH, 16'h0181, 16'h0000, 1'b0);
        run_op(0, kXOR, 16'hA5A5, 16'hA5A5, 1'b0);
        run_op(0, kAND, 16'hF0F0, 16'hFF00, 1'b0);

        // Reset in PASS2 aborts the operation.
        drive(0, 1'b1, kOR, 16'h1357, 16'h2468, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.REQ0 = 1'b0;
        #1;
        check("abort_busy", bus.BUSY, 0);
        check("abort_acks", {bus.ACK1, bus.ACK0}, 2'b00);
        check("abort_result", bus.RESULT, 16'h0000);
        check("abort_sc", bus.SC_RESULT, 0);
        check("abort_zero", bus.ZERO_RESULT, 1);
        check("abort_alu_a", bus.ALU_A, 8'h00);
        check("abort_alu_op", bus.ALU_OP, kAND);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.ACK0 || bus.ACK1) late_ack = 1'b1;
        end
        check("abort_no_ack", late_ack, 0);
        run_op(1, kRSH, 16'h8001, 16'h0000, 1'b1);

        // Random single-requester operations.
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Port: CLK  in  1  rising-edge clock.
REQ-003 Port: RESET_N  in  1  asynchronous reset, active low.
REQ-004 Ports: REQ0, REQ1  in  1  requester n wants a 16-bit operation.
REQ-005 Ports: OP0, OP1  in  3  requester n opcode, encoded per op_mne in the definitions package.
REQ-006 Ports: A0, B0, A1, B1  in  16  requester n operands.
REQ-007 Ports: SCIN0, SCIN1  in  1  requester n shift-in bit.
REQ-008 Ports: ACK0, ACK1  out  1  one-cycle completion pulse to requester n.
REQ-009 Ports: RESULT  out  16, SC_RESULT  out  1, ZERO_RESULT  out  1  latched result, shift-out bit, RESULT==0 flag.
REQ-010 Port: BUSY  out  1  high in every state except IDLE.
REQ-011 Ports: ALU_A, ALU_B  out  8, ALU_OP  out  3, ALU_SC_IN  out  1  drive the shared 8-bit ALU.
REQ-012 Ports: ALU_OUT  in  8, ALU_SC_OUT  in  1  combinational ALU result and carry/shift out.

Function
REQ-013 The FSM SHALL have four states: IDLE, PASS1, PASS2, DONE.
REQ-014 IDLE, no REQ high: remain in IDLE.
REQ-015 IDLE, any REQ high at an edge: grant one requester, latch its OP, A, B and SCIN, and go to PASS1.
REQ-016 Arbitration: a sole requester wins; on a tie, the requester not granted last wins (round-robin LAST register).
REQ-017 Operand and REQ changes after grant SHALL be ignored until the state returns to IDLE.
REQ-018 PASS1 -> PASS2 and PASS2 -> DONE SHALL each be unconditional, one cycle.
REQ-019 DONE: the granted ACK SHALL be high for exactly this cycle; next state IDLE.
REQ-020 Latency: the IDLE sampling edge is edge k; PASS1 is cycle k+1, PASS2 k+2, ACK high in cycle k+3.
REQ-021 Throughput: at most one operation per 4 cycles.
REQ-022 kLSH byte order: PASS1 = low byte with ALU_SC_IN=SCIN; PASS2 = high byte with ALU_SC_IN = carry register.
REQ-023 kRSH byte order: PASS1 = high byte with ALU_SC_IN=SCIN; PASS2 = low byte with ALU_SC_IN = carry register.
REQ-024 kAND, kXOR and all other opcodes: PASS1 = low byte, PASS2 = high byte, ALU_SC_IN=0.
REQ-025 Each PASS SHALL drive ALU_A and ALU_B with the selected operand byte and ALU_OP with the latched opcode.
REQ-026 PASS1 SHALL register ALU_OUT into the corresponding result byte and ALU_SC_OUT into the carry register.
REQ-027 PASS2 SHALL register ALU_OUT into the other result byte.
REQ-028 PASS2 SHALL register SC_RESULT = ALU_SC_OUT for kLSH/kRSH, else 0.
REQ-029 ZERO_RESULT SHALL be updated with RESULT at the PASS2 edge.
REQ-030 RESULT, SC_RESULT and ZERO_RESULT SHALL hold their value from DONE until the next operation's PASS2 edge.
REQ-031 IDLE and DONE: ALU_A=0, ALU_B=0, ALU_SC_IN=0, ALU_OP=kAND.
REQ-032 Requester protocol: hold REQ until ACK; a REQ dropped before grant is not served.
REQ-033 A REQ still high in the IDLE cycle after DONE is a new request and is arbitrated normally.
REQ-034 ACK0 and ACK1 SHALL never be high together.

Reset
REQ-035 RESET_N low SHALL immediately force: state IDLE; ACK0, ACK1, BUSY = 0; RESULT = 0, SC_RESULT = 0, ZERO_RESULT = 1; carry = 0; LAST = 1 (requester 0 wins the first tie); ALU outputs per REQ-031.
REQ-036 Reset asserted in any state SHALL abort the operation with no ACK.
REQ-037 After RESET_N deasserts, the first edge SHALL be evaluated from IDLE.

Verification
REQ-038 Bench: REQ0, OP0=kLSH, A0=16'h80FF, SCIN0=1 -> ACK0 in cycle k+3, RESULT=16'h01FF, SC_RESULT=1, ZERO_RESULT=0.
REQ-039 Bench: REQ1, OP1=kRSH, A1=16'h0181, SCIN1=0 -> RESULT=16'h00C0, SC_RESULT=1; PASS1 drives ALU_A=8'h01.
REQ-040 Bench: OP0=kXOR, A0=B0=16'hA5A5 -> RESULT=0, ZERO_RESULT=1, SC_RESULT=0.
REQ-041 Bench: REQ0 and REQ1 both held high from reset -> ACK order 0,1,0,1, ACKs 4 cycles apart, never overlapping.
REQ-042 Bench: OP0=kAND, A0=16'hF0F0, B0=16'hFF00, then A0 changed to 16'h0000 in PASS1 -> RESULT=16'hF000.
REQ-043 Bench: RESET_N pulsed low during PASS2 -> outputs at reset values immediately, no ACK; new request after release completes normally.
